// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq_core: operand request side, result side,
// flags and sticky-overflow control. slave = ALU, master = source/sink.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             c_out;
  logic             overflow;
  logic             sticky_ovf;
  logic             sticky_clr;

  modport slave (
    input  in_valid, op1, op2, opcode,
    input  out_ready, sticky_clr,
    output in_ready, out_valid, result,
    output zero, c_out, overflow, sticky_ovf
  );

  modport master (
    output in_valid, op1, op2, opcode,
    output out_ready, sticky_clr,
    input  in_ready, out_valid, result,
    input  zero, c_out, overflow, sticky_ovf
  );
endinterface

// File: rtl/alu_seq_core.sv
// Registered, handshaked ALU: 7 single-cycle ops plus iterative multiply.
// Ports: clk, rst (async, active-high), bus (alu_seq_if.slave).
module alu_seq_core #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_q, c_d;
  logic               v_q, v_d;
  logic               stk_q, stk_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic               sc_v;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] prod;
  logic               last;

  assign in_ready = (state_q == S_IDLE) ||
                    ((state_q == S_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = (bus.opcode == OP_MUL) && MUL_EN;

  assign sum = {1'b0, bus.op1} + {1'b0, bus.op2};
  // Subtract as op1 + ~op2 + 1 so carry-out reads as "no borrow".
  assign dif = {1'b0, bus.op1} + {1'b0, ~bus.op2}
             + (WIDTH+1)'(1);

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    unique case (1'b1)
      (bus.opcode == OP_MOV):  sc_res = bus.op2;
      (bus.opcode == OP_NOT):  sc_res = ~bus.op1;
      (bus.opcode == OP_ADD): begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) &&
                 (sum[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      (bus.opcode == OP_NOR):  sc_res = ~(bus.op1 | bus.op2);
      (bus.opcode == OP_SUB): begin
        sc_res = dif[WIDTH-1:0];
        sc_c   = dif[WIDTH];
        sc_v   = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) &&
                 (dif[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      (bus.opcode == OP_NAND): sc_res = ~(bus.op1 & bus.op2);
      (bus.opcode == OP_AND):  sc_res = bus.op1 & bus.op2;
      // Reached for mul only when the multiplier is disabled.
      (bus.opcode == OP_MUL):  sc_res = '0;
      default:                 sc_res = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the
  // current multiplier LSB is set.
  assign addend = mplr_q[0] ? mcand_q : '0;
  assign prod   = acc_q + addend;
  assign last   = (cnt_q == CW'(WIDTH-1));

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    c_d     = c_q;
    v_d     = v_q;
    stk_d   = bus.sticky_clr ? 1'b0 : stk_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = S_BUSY;
            mcand_d = {{WIDTH{1'b0}}, bus.op1};
            mplr_d  = bus.op2;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            res_d   = sc_res;
            c_d     = sc_c;
            v_d     = sc_v;
            // A set on the same edge as a clear wins.
            if (sc_v) stk_d = 1'b1;
          end
        end else if (state_q == S_DONE && bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d   = prod;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          res_d   = prod[WIDTH-1:0];
          c_d     = |prod[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      stk_q   <= 1'b0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      c_q     <= c_d;
      v_q     <= v_d;
      stk_q   <= stk_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.result     = res_q;
  assign bus.zero       = (res_q == '0);
  assign bus.c_out      = c_q;
  assign bus.overflow   = v_q;
  assign bus.sticky_ovf = stk_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH=8) with a result
// scoreboard fed at issue time and drained by an output monitor.
module tb_alu_seq_core;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq_core #(
    .WIDTH (W),
    .MUL_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t scb[$];
  int   pop_cyc[$];
  exp_t mon_e;
  exp_t mon_g;

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int sa;
    int sb;
    int s;
    logic [2*W-1:0] p;
    e  = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: e.res = b;
      3'd1: e.res = ~a;
      3'd2: begin
        e.res = a + b;
        e.c   = (int'(a) + int'(b)) > 255;
        s     = sa + sb;
        e.v   = (s > 127) || (s < -128);
      end
      3'd3: e.res = ~(a | b);
      3'd4: begin
        e.res = a - b;
        e.c   = (a >= b);
        s     = sa - sb;
        e.v   = (s > 127) || (s < -128);
      end
      3'd5: e.res = ~(a & b);
      3'd6: e.res = a & b;
      default: begin
        p     = a * b;
        e.res = p[W-1:0];
        e.c   = (p[2*W-1:W] != 0);
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_chk++;
      mon_g = {bus.result, bus.c_out, bus.overflow, bus.zero};
      if (scb.size() == 0) begin
        $display("FAIL unexpected_output got=%h required none",
                 mon_g);
      end else begin
        mon_e = scb.pop_front();
        pop_cyc.push_back(cyc);
        if (mon_g !== mon_e)
          $display("FAIL result_flags got res=%h c=%b v=%b z=%b required res=%h c=%b v=%b z=%b",
                   mon_g.res, mon_g.c, mon_g.v, mon_g.z,
                   mon_e.res, mon_e.c, mon_e.v, mon_e.z);
        else
          n_pass++;
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input bit track);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.op1      = a;
    bus.op2      = b;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        if (track) scb.push_back(model(op, a, b));
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      $display("FAIL issue_timeout op=%0d got no accept required accept",
               op);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.zero,
         bus.c_out, bus.overflow, bus.sticky_ovf} !== 14'b10_00000000_1000)
      $display("FAIL reset_state got rdy=%b vld=%b res=%h z=%b c=%b v=%b s=%b required 1 0 00 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.zero,
               bus.c_out, bus.overflow, bus.sticky_ovf);
    else
      n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    issue(3'b111, 8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.zero,
         bus.sticky_ovf} !== 12'b01_00000000_10)
      $display("FAIL reset_mid_mul got vld=%b rdy=%b res=%h z=%b s=%b required 0 1 00 1 0",
               bus.out_valid, bus.in_ready, bus.result, bus.zero,
               bus.sticky_ovf);
    else
      n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0)
      $display("FAIL abandoned_mul got out_valid=1 required 0");
    else
      n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    issue(3'b010, 8'h7F, 8'h01, 1'b1);
    n_chk++;
    if (bus.sticky_ovf !== 1'b1)
      $display("FAIL sticky_set got %b required 1", bus.sticky_ovf);
    else
      n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1)
      $display("FAIL add_latency got out_valid=%b required 1",
               bus.out_valid);
    else
      n_pass++;
    @(posedge clk);
    #1;
    issue(3'b010, 8'hFF, 8'h01, 1'b1);
    n_chk++;
    if (bus.sticky_ovf !== 1'b1)
      $display("FAIL sticky_hold got %b required 1", bus.sticky_ovf);
    else
      n_pass++;
  endtask

  task automatic test_sub();
    issue(3'b100, 8'h80, 8'h01, 1'b1);
    issue(3'b100, 8'h00, 8'h01, 1'b1);
    issue(3'b100, 8'h55, 8'h55, 1'b1);
  endtask

  task automatic test_mul();
    int  n;
    bit  busy_ok;
    issue(3'b111, 8'h10, 8'h10, 1'b1);
    n = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) n = i;
      else if (bus.in_ready) busy_ok = 1'b0;
    end
    n_chk++;
    if (n !== 9)
      $display("FAIL mul_latency got %0d required 9", n);
    else
      n_pass++;
    n_chk++;
    if (busy_ok !== 1'b1)
      $display("FAIL mul_busy_ready got in_ready=1 required 0");
    else
      n_pass++;
    @(posedge clk);
    #1;
    issue(3'b111, 8'h0F, 8'h03, 1'b1);
    issue(3'b111, 8'hFF, 8'hFF, 1'b1);
    issue(3'b111, 8'h80, 8'h02, 1'b1);
    repeat (3)
      issue(3'b111, 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic test_backpressure();
    bit stable;
    repeat (12) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(3'b110, 8'hF0, 8'h3C, 1'b1);
    bus.in_valid = 1'b1;
    bus.opcode   = 3'b011;
    bus.op1      = 8'h00;
    bus.op2      = 8'h00;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(bus.out_valid === 1'b1 && bus.result === 8'h30 &&
            bus.in_ready === 1'b0))
        stable = 1'b0;
    end
    n_chk++;
    if (stable !== 1'b1)
      $display("FAIL backpressure_hold got unstable required res=30 rdy=0");
    else
      n_pass++;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL release_ready got %b required 1", bus.in_ready);
    else
      n_pass++;
    scb.push_back(model(3'b011, 8'h00, 8'h00));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (!(bus.out_valid === 1'b1 && bus.result === 8'hFF))
      $display("FAIL no_bubble got vld=%b res=%h required 1 ff",
               bus.out_valid, bus.result);
    else
      n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    repeat (2) @(posedge clk);
    #1 pop_cyc.delete();
    issue(3'b000, 8'h12, 8'h34, 1'b1);
    issue(3'b001, 8'hA5, 8'h00, 1'b1);
    issue(3'b101, 8'hF0, 8'h3C, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (pop_cyc.size() !== 3)
      $display("FAIL stream_count got %0d required 3", pop_cyc.size());
    else if (pop_cyc[1] - pop_cyc[0] !== 1 ||
             pop_cyc[2] - pop_cyc[1] !== 1)
      $display("FAIL stream_gap got %0d,%0d required 1,1",
               pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1]);
    else
      n_pass++;
  endtask

  task automatic test_sticky();
    bus.sticky_clr = 1'b1;
    @(posedge clk);
    #1 bus.sticky_clr = 1'b0;
    n_chk++;
    if (bus.sticky_ovf !== 1'b0)
      $display("FAIL sticky_clear got %b required 0", bus.sticky_ovf);
    else
      n_pass++;
    issue(3'b010, 8'h01, 8'h01, 1'b1);
    n_chk++;
    if (bus.sticky_ovf !== 1'b0)
      $display("FAIL sticky_no_ovf got %b required 0", bus.sticky_ovf);
    else
      n_pass++;
    bus.sticky_clr = 1'b1;
    issue(3'b010, 8'h7F, 8'h7F, 1'b1);
    bus.sticky_clr = 1'b0;
    n_chk++;
    if (bus.sticky_ovf !== 1'b1)
      $display("FAIL sticky_set_wins got %b required 1", bus.sticky_ovf);
    else
      n_pass++;
  endtask

  task automatic test_random();
    repeat (30)
      issue(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'b1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.op1        = '0;
    bus.op2        = '0;
    bus.opcode     = '0;
    bus.out_ready  = 1'b1;
    bus.sticky_clr = 1'b0;
    test_reset();
    test_reset_mid_mul();
    test_add();
    test_sub();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_sticky();
    test_random();
    for (int i = 0; i < 40 && scb.size() != 0; i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    n_chk++;
    if (scb.size() !== 0)
      $display("FAIL drain got %0d pending required 0", scb.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Registered, handshaked successor to the team's combinational N-bit ALU.
- Keeps the seven existing operations: mov, not, add, nor, sub, nand, and.
- Adds an iterative multi-cycle unsigned multiply on the previously unused opcode 111.
- Adds valid/ready flow control on both sides and a sticky flag accumulator.
- Sits between the operand-fetch stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).
- MUL_EN, 1, 1 enables opcode 111 multiply; 0 turns opcode 111 into a single-cycle op that returns 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high; clears all state.
- in_valid  input  1  operands and opcode are valid this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- op1  input  WIDTH  first operand.
- op2  input  WIDTH  second operand.
- opcode  input  3  000 mov, 001 not, 010 add, 011 nor, 100 sub, 101 nand, 110 and, 111 mul.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- c_out  output  1  carry / borrow-inverted / multiply high-part-nonzero.
- overflow  output  1  signed overflow (add and sub only).
- sticky_ovf  output  1  OR of every overflow delivered since reset or clear.
- sticky_clr  input  1  synchronous clear of sticky_ovf.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, in_ready=1, out_valid=0.
  - result=0, zero=1, c_out=0, overflow=0, sticky_ovf=0.
  - Any in-flight multiply is abandoned; no output is produced for it.
- Accept occurs when in_valid && in_ready at a rising edge; operands and opcode are captured at that edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue with no bubble.
- States:
  - IDLE: no result held.
  - BUSY: multiply iterating.
  - DONE: out_valid=1, result held.
- Transitions:
  - IDLE, accept of a single-cycle op -> DONE; result registered at the accept edge. Latency is 1 cycle (out_valid high the cycle after acceptance).
  - IDLE, accept of mul with MUL_EN=1 -> BUSY, counter=0, accumulator=0.
  - BUSY: one shift-add step per cycle on a 2*WIDTH product. After WIDTH steps -> DONE. out_valid rises WIDTH+1 cycles after acceptance. in_ready=0 throughout BUSY.
  - DONE, out_ready=1 with no accept -> IDLE.
  - DONE, out_ready=1 with an accept -> behaves as the IDLE-accept transition in the same edge.
  - DONE, out_ready=0: hold result and all flags stable; in_ready=0.
- Arithmetic (all operands unsigned, WIDTH bits):
  - mov: result = op2.
  - not: result = ~op1.
  - add: {c_out, result} = op1 + op2.
  - sub: {c_out, result} = op1 + ~op2 + 1, so c_out=1 means no borrow.
  - nor, nand, and: bitwise.
  - mul: result = low WIDTH bits of op1*op2; c_out = (high WIDTH bits != 0).
- Overflow:
  - add: op1 and op2 have equal MSBs and the result MSB differs from them.
  - sub: op1 and op2 MSBs differ and the result MSB differs from op1's MSB.
  - All other ops: 0.
  - c_out is 0 for every op except add, sub and mul.
- zero is computed from the registered result for every op.
- sticky_ovf:
  - Set at the edge where a result with overflow=1 enters DONE.
  - sticky_clr=1 clears it at the next edge.
  - If clear and set coincide, set wins.
- Flags and result change only on a transition into DONE; they are never glitched by new inputs while held.
- in_valid while in_ready=0 is ignored; the source must hold its request.

Test Plan:
- WIDTH=8. Reset asserted mid-BUSY on mul 0xFF*0xFF -> next cycle out_valid=0, in_ready=1, result=0x00, zero=1, sticky_ovf=0.
- add 0x7F+0x01 -> one cycle later: result=0x80, overflow=1, c_out=0, zero=0; sticky_ovf=1 thereafter. add 0xFF+0x01 -> result=0x00, c_out=1, zero=1, overflow=0.
- sub 0x80-0x01 -> result=0x7F, overflow=1, c_out=1. sub 0x00-0x01 -> result=0xFF, c_out=0, overflow=0.
- mul 0x10*0x10 -> out_valid exactly 9 cycles after accept, in_ready=0 during the 8 BUSY cycles; result=0x00, c_out=1, zero=1. mul 0x0F*0x03 -> result=0x2D, c_out=0.
- Backpressure: hold out_ready=0 for 5 cycles after "and 0xF0,0x3C" -> result=0x30 stable, in_ready=0. Then out_ready=1 with "nor 0x00,0x00" presented -> accepted in the same edge, next result=0xFF, no bubble.
- Streaming: mov, not, nand on consecutive cycles with out_ready=1 -> results op2, ~op1, ~(op1&op2) on consecutive cycles. sticky_clr and an overflowing add landing in the same edge -> sticky_ovf stays 1.
